// File: rtl/usart_rx.sv
// Oversampling 8N1/8-parity-1 receiver with an internal FWFT FIFO; word visible the cycle after its stop decision tick.
// No backpressure: a good word that finds the FIFO full with no pop is dropped and flagged. Parity enabled by USART_RX_PARITY_EN.
module usart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick_i,
    input  logic                 rx_i,
    input  logic                 parity_odd_i,
    input  logic                 rd_en_i,
    input  logic                 clr_err_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    output logic                 frame_err_o,
    output logic                 parity_err_o,
    output logic                 overrun_o
);

    localparam int TCW = $clog2(OVERSAMPLE);
    localparam int BCW = $clog2(DATA_BITS);
    localparam int PW  = $clog2(FIFO_DEPTH);

    localparam logic [TCW-1:0] TC_LO   = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_MID  = TCW'(OVERSAMPLE / 2);
    localparam logic [TCW-1:0] TC_HI   = TCW'(OVERSAMPLE / 2 + 1);
    localparam logic [TCW-1:0] TC_MAX  = TCW'(OVERSAMPLE - 1);
    localparam logic [BCW-1:0] BC_LAST = BCW'(DATA_BITS - 1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
`ifdef USART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd3;
`endif
    localparam logic [2:0] ST_STOP   = 3'd4;

    logic                 rx_s1_q, rx_s1_d, rx_s2_q, rx_s2_d;
    logic [2:0]           state_q, state_d;
    logic [TCW-1:0]       tc_q, tc_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [1:0]           samp_q, samp_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_BITS-1:0] mem_d [FIFO_DEPTH];
    logic [PW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 fe_q, fe_d, ov_q, ov_d;
    logic                 rxs, maj, push, fe_set, full, pop, do_push;

`ifdef USART_RX_PARITY_EN
    logic par_bit_q, par_bit_d, pe_q, pe_d, pe_set, par_bad;
    assign par_bad      = par_bit_q ^ (^shift_q) ^ parity_odd_i;
    assign parity_err_o = pe_q;
`else
    logic unused_parity;
    assign unused_parity = parity_odd_i;
    assign parity_err_o  = 1'b0;
`endif

    assign rxs = rx_s2_q;
    // Third vote is the live sample taken on the decision tick itself.
    assign maj = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);

    always_comb begin
        rx_s1_d   = rx_i;
        rx_s2_d   = rx_s1_q;
        state_d   = state_q;
        tc_d      = tc_q;
        bit_cnt_d = bit_cnt_q;
        samp_d    = samp_q;
        shift_d   = shift_q;
        push      = 1'b0;
        fe_set    = 1'b0;
`ifdef USART_RX_PARITY_EN
        par_bit_d = par_bit_q;
        pe_set    = 1'b0;
`endif
        if (baud_tick_i) begin
            if (state_q == ST_IDLE) begin
                if (!rxs) begin
                    state_d = ST_START;
                    tc_d    = '0;
                end
            end else begin
                tc_d = (tc_q == TC_MAX) ? '0 : tc_q + 1'b1;
                if (tc_q == TC_LO)  samp_d[0] = rxs;
                if (tc_q == TC_MID) samp_d[1] = rxs;
                if (tc_q == TC_HI) begin
                    case (state_q)
                        ST_START: begin
                            if (maj) begin
                                state_d = ST_IDLE;
                                tc_d    = '0;
                            end else begin
                                state_d   = ST_DATA;
                                bit_cnt_d = '0;
                            end
                        end
                        ST_DATA: begin
                            shift_d = {maj, shift_q[DATA_BITS-1:1]};
                            if (bit_cnt_q == BC_LAST) begin
`ifdef USART_RX_PARITY_EN
                                state_d = ST_PARITY;
`else
                                state_d = ST_STOP;
`endif
                            end else begin
                                bit_cnt_d = bit_cnt_q + 1'b1;
                            end
                        end
`ifdef USART_RX_PARITY_EN
                        ST_PARITY: begin
                            par_bit_d = maj;
                            state_d   = ST_STOP;
                        end
`endif
                        ST_STOP: begin
                            // Return to idle at mid-stop so a fast next start edge is not missed.
                            state_d = ST_IDLE;
                            tc_d    = '0;
                            if (!maj) fe_set = 1'b1;
`ifdef USART_RX_PARITY_EN
                            else if (par_bad) pe_set = 1'b1;
`endif
                            else push = 1'b1;
                        end
                        default: begin
                            state_d = ST_IDLE;
                            tc_d    = '0;
                        end
                    endcase
                end
            end
        end
    end

    assign valid_o = (wr_ptr_q != rd_ptr_q);
    assign full    = (wr_ptr_q[PW] != rd_ptr_q[PW]) && (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
    assign pop     = rd_en_i & valid_o;
    assign do_push = push & (~full | pop);
    assign data_o  = data_q;
    assign frame_err_o = fe_q;
    assign overrun_o   = ov_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[PW-1:0]] = shift_q;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
        // Head is registered so data_o keeps its last value once the FIFO drains.
        data_d = (wr_ptr_d != rd_ptr_d) ? mem_d[rd_ptr_d[PW-1:0]] : data_q;
        fe_d   = (fe_q & ~clr_err_i) | fe_set;
        ov_d   = (ov_q & ~clr_err_i) | (push & full & ~pop);
`ifdef USART_RX_PARITY_EN
        pe_d   = (pe_q & ~clr_err_i) | pe_set;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            state_q   <= ST_IDLE;
            tc_q      <= '0;
            bit_cnt_q <= '0;
            samp_q    <= '0;
            shift_q   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            data_q    <= '0;
            fe_q      <= 1'b0;
            ov_q      <= 1'b0;
`ifdef USART_RX_PARITY_EN
            par_bit_q <= 1'b0;
            pe_q      <= 1'b0;
`endif
        end else begin
            rx_s1_q   <= rx_s1_d;
            rx_s2_q   <= rx_s2_d;
            state_q   <= state_d;
            tc_q      <= tc_d;
            bit_cnt_q <= bit_cnt_d;
            samp_q    <= samp_d;
            shift_q   <= shift_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            data_q    <= data_d;
            fe_q      <= fe_d;
            ov_q      <= ov_d;
`ifdef USART_RX_PARITY_EN
            par_bit_q <= par_bit_d;
            pe_q      <= pe_d;
`endif
        end
    end

endmodule

// File: tb/tb_usart_rx.sv
// Directed bench for usart_rx: a queue/flag model predicts FIFO and sticky flags, checked every cycle.
module tb_usart_rx;
    localparam int DB = 8;
    localparam int OS = 16;
    localparam int FD = 4;
`ifdef USART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          baud_tick_i = 1'b0;
    logic          rx_i = 1'b1;
    logic          parity_odd_i = 1'b0;
    logic          rd_en_i = 1'b0;
    logic          clr_err_i = 1'b0;
    logic [DB-1:0] data_o;
    logic          valid_o, frame_err_o, parity_err_o, overrun_o;

    always #5 clk = ~clk;

    usart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst), .baud_tick_i(baud_tick_i), .rx_i(rx_i),
        .parity_odd_i(parity_odd_i), .rd_en_i(rd_en_i), .clr_err_i(clr_err_i),
        .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o),
        .parity_err_o(parity_err_o), .overrun_o(overrun_o)
    );

    int       vecs = 0;
    int       errs = 0;
    logic [7:0] exp_q[$];
    bit       exp_fe = 0, exp_pe = 0, exp_ov = 0;
    bit       chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        vecs++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("valid", {31'd0, valid_o}, {31'd0, exp_q.size() > 0});
            if (exp_q.size() > 0) chk("data", {24'd0, data_o}, {24'd0, exp_q[0]});
            chk("frame_err", {31'd0, frame_err_o}, {31'd0, exp_fe});
            chk("parity_err", {31'd0, parity_err_o}, {31'd0, exp_pe});
            chk("overrun", {31'd0, overrun_o}, {31'd0, exp_ov});
        end
    end

    // ev: 0 none, 1 good word w, 2 framing error, 3 parity error
    task automatic cyc(input bit tk, input bit rd, input bit clr, input int ev, input logic [7:0] w);
        baud_tick_i = tk;
        rd_en_i     = rd;
        clr_err_i   = clr;
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            exp_fe = 0; exp_pe = 0; exp_ov = 0;
        end else begin
            if (rd && exp_q.size() > 0) void'(exp_q.pop_front());
            if (clr) begin exp_fe = 0; exp_pe = 0; exp_ov = 0; end
            case (ev)
                1: if (exp_q.size() < FD) exp_q.push_back(w); else exp_ov = 1;
                2: exp_fe = 1;
                3: exp_pe = 1;
                default: ;
            endcase
        end
        baud_tick_i = 0;
        rd_en_i     = 0;
        clr_err_i   = 0;
    endtask

    // One baud tick every 3 clocks; line changes 2 clocks ahead of the tick so rxs has settled.
    task automatic raw_ticks(input bit v, input int n);
        for (int t = 0; t < n; t++) begin
            rx_i = v;
            cyc(0, 0, 0, 0, 8'h00);
            cyc(0, 0, 0, 0, 8'h00);
            cyc(1, 0, 0, 0, 8'h00);
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input bit par_flip, input bit stop_bit,
                              input bit rd_on_stop, input int rst_tick);
        bit ln [12];
        int nb, stop_tick, ev;
        nb = 2 + DB + PB;
        ln[0] = 1'b0;
        for (int i = 0; i < DB; i++) ln[1+i] = d[i];
        if (PB == 1) ln[1+DB] = (^d) ^ parity_odd_i ^ par_flip;
        ln[nb-1] = stop_bit;
        // START entered with tc=0 on the detecting tick; decision at tc=OS/2+1, then every OS ticks.
        stop_tick = OS / 2 + 2 + OS * (nb - 1);
        if (!stop_bit) ev = 2;
        else if (PB == 1 && par_flip) ev = 3;
        else ev = 1;
        for (int t = 0; t < nb * OS; t++) begin
            rx_i = ln[t / OS];
            if (t == rst_tick) rst = 1;
            cyc(0, 0, 0, 0, 8'h00);
            cyc(0, 0, 0, 0, 8'h00);
            rst = 0;
            cyc(1, rd_on_stop && (t == stop_tick), 0,
                (t == stop_tick && rst_tick < 0) ? ev : 0, d);
        end
        rx_i = 1'b1;
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] expv);
        chk(nm, {24'd0, data_o}, {24'd0, expv});
        rx_i = 1'b1;
        cyc(0, 1, 0, 0, 8'h00);
    endtask

    task automatic clr_err();
        cyc(0, 0, 1, 0, 8'h00);
    endtask

    initial begin
        rst = 1;
        repeat (3) cyc(0, 0, 0, 0, 8'h00);
        rst = 0;
        chk_en = 1;
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_data", {24'd0, data_o}, 32'd0);
        chk("rst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        raw_ticks(1, 4);

        // single word then pop
        send_frame(8'hA5, 0, 1, 0, -1);
        chk("a5_valid", {31'd0, valid_o}, 32'd1);
        pop_chk("a5_data", 8'hA5);
        chk("a5_empty", {31'd0, valid_o}, 32'd0);
        chk("a5_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);

        // false start then a good frame
        raw_ticks(0, 4);
        raw_ticks(1, 12);
        chk("fs_valid", {31'd0, valid_o}, 32'd0);
        chk("fs_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        send_frame(8'h5A, 0, 1, 0, -1);
        pop_chk("5a_data", 8'h5A);

        // framing error
        send_frame(8'h3C, 0, 0, 0, -1);
        raw_ticks(1, 16);
        chk("fe_set", {31'd0, frame_err_o}, 32'd1);
        chk("fe_valid", {31'd0, valid_o}, 32'd0);
        clr_err();
        chk("fe_clr", {31'd0, frame_err_o}, 32'd0);

        // overrun
        for (int i = 1; i <= 5; i++) send_frame(i[7:0], 0, 1, 0, -1);
        chk("ov_set", {31'd0, overrun_o}, 32'd1);
        pop_chk("ov_rd1", 8'h01);
        pop_chk("ov_rd2", 8'h02);
        pop_chk("ov_rd3", 8'h03);
        pop_chk("ov_rd4", 8'h04);
        chk("ov_empty", {31'd0, valid_o}, 32'd0);
        clr_err();
        chk("ov_clr", {31'd0, overrun_o}, 32'd0);

        // full FIFO with a pop on the fifth stop decision: no overrun
        for (int i = 1; i <= 4; i++) send_frame(i[7:0], 0, 1, 0, -1);
        send_frame(8'h05, 0, 1, 1, -1);
        chk("nov_flag", {31'd0, overrun_o}, 32'd0);
        pop_chk("nov_rd2", 8'h02);
        pop_chk("nov_rd3", 8'h03);
        pop_chk("nov_rd4", 8'h04);
        pop_chk("nov_rd5", 8'h05);
        chk("nov_empty", {31'd0, valid_o}, 32'd0);

`ifdef USART_RX_PARITY_EN
        parity_odd_i = 0;
        send_frame(8'h07, 1, 1, 0, -1);
        chk("pe_set", {31'd0, parity_err_o}, 32'd1);
        chk("pe_valid", {31'd0, valid_o}, 32'd0);
        send_frame(8'h07, 0, 1, 0, -1);
        pop_chk("pe_good", 8'h07);
        clr_err();
        chk("pe_clr", {31'd0, parity_err_o}, 32'd0);
`endif

        // reset during data bit 4 after leaving a sticky flag set
        send_frame(8'h3C, 0, 0, 0, -1);
        raw_ticks(1, 16);
        chk("pre_rst_fe", {31'd0, frame_err_o}, 32'd1);
        send_frame(8'hFF, 0, 1, 0, 5 * OS + 8);
        chk("mrst_valid", {31'd0, valid_o}, 32'd0);
        chk("mrst_data", {24'd0, data_o}, 32'd0);
        chk("mrst_flags", {29'd0, frame_err_o, parity_err_o, overrun_o}, 32'd0);
        send_frame(8'h81, 0, 1, 0, -1);
        pop_chk("mrst_81", 8'h81);
        chk("end_pe", {31'd0, parity_err_o}, 32'd0);
        raw_ticks(1, 2);

        chk_en = 0;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
